// File: rtl/pd_pkg.sv
// Shared types and constants for the pd_serializer front end.
//   pd_state_e   : shift-path state (idle / shifting)
//   PD_DEF_WIDTH : default word width
//   pd_out_pos() : position of the bit presented first for a given bit order
package pd_pkg;

    typedef enum logic {
        PD_IDLE  = 1'b0,
        PD_SHIFT = 1'b1
    } pd_state_e;

    localparam int unsigned PD_DEF_WIDTH = 8;

    // Bit position that holds the next serial bit in the output shift register.
    function automatic int unsigned pd_out_pos(input int unsigned width, input bit msb_first);
        return msb_first ? (width - 1) : 0;
    endfunction

endpackage

// File: rtl/pd_hold_buf.sv
// One-entry holding buffer between the word handshake and the shift path.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture word_i (buffer must be empty)
//   drain_i      : buffer content moves into the shift path this edge
//   word_i       : word to capture
//   word_o       : buffered word
//   full_o       : buffer holds a word
//   ready_o      : registered inverse of the full flag
module pd_hold_buf
    import pd_pkg::*;
#(
    parameter int unsigned WIDTH = PD_DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] word_i,
    output logic [WIDTH-1:0] word_o,
    output logic             full_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;
    logic             ready_q;

    // Next buffer contents; a drain always wins since no load can coincide with it.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (drain_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            data_d = word_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            data_q  <= data_d;
            full_q  <= full_d;
            ready_q <= ~full_d;
        end
    end

    assign word_o  = data_q;
    assign full_o  = full_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/pd_serializer.sv
// Parallel-to-serial front end feeding the pdm pattern detector.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   word_i        : parallel word, accepted when word_valid_i & word_ready_o
//   word_valid_i  : word_i is valid
//   word_ready_o  : a word can be accepted this cycle
//   hold_i        : pause the serial stream without losing bits
//   data_o        : serial bit
//   valid_o       : data_o carries a bit this cycle
//   last_o        : final bit of a word
//   busy_o        : a word is being shifted or is buffered
module pd_serializer
    import pd_pkg::*;
#(
    parameter int unsigned WIDTH     = PD_DEF_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    input  logic             hold_i,
    output logic             data_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam int unsigned      OUT_POS  = pd_out_pos(WIDTH, MSB_FIRST);

    pd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] buf_word;
    logic             buf_full;
    logic             buf_ready;

    logic             accept_c;
    logic             advance_c;
    logic             drain_c;
    logic             bypass_c;
    logic             buf_load_c;
    logic [WIDTH-1:0] next_word_c;
    logic [WIDTH-1:0] shifted_c;

    // Handshake and shift-path advance decisions.
    assign accept_c    = word_valid_i & buf_ready;
    assign advance_c   = ~hold_i & ((state_q == PD_IDLE) | (cnt_q == LAST_CNT));
    assign drain_c     = advance_c & buf_full;
    assign bypass_c    = advance_c & ~buf_full & accept_c;
    assign buf_load_c  = accept_c & ~advance_c;
    assign next_word_c = buf_full ? buf_word : word_i;

    // The presented bit always sits at OUT_POS; shifting exposes the next one.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_c = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted_c = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    pd_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (buf_load_c),
        .drain_i (drain_c),
        .word_i  (word_i),
        .word_o  (buf_word),
        .full_o  (buf_full),
        .ready_o (buf_ready)
    );

    // Next-state and output logic; hold freezes everything except valid/last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;

        if (!hold_i) begin
            if (advance_c) begin
                if (drain_c || bypass_c) begin
                    state_d = PD_SHIFT;
                    cnt_d   = '0;
                    shreg_d = next_word_c;
                    data_d  = next_word_c[OUT_POS];
                    valid_d = 1'b1;
                end else begin
                    state_d = PD_IDLE;
                end
            end else if (state_q == PD_SHIFT) begin
                cnt_d   = cnt_q + CNT_W'(1);
                shreg_d = shifted_c;
                data_d  = shifted_c[OUT_POS];
                valid_d = 1'b1;
                last_d  = (cnt_d == LAST_CNT);
            end
        end

        busy_d = (state_d == PD_SHIFT) | (buf_full & ~drain_c) | buf_load_c;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PD_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign word_ready_o = buf_ready;
    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign last_o       = last_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_pd_serializer.sv
// Bench for pd_serializer: u0 is WIDTH=6 MSB-first, u1 is WIDTH=8 LSB-first.
// A queue-based model predicts every output each cycle; directed sequences
// additionally pin captured bit streams to hand-computed constants.
module tb_pd_serializer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       hold_i;
    logic [5:0] word6;
    logic [7:0] word8;
    logic [1:0] wv, rdy, dat, vo, lo, bo;

    always #5 clk = ~clk;

    pd_serializer #(.WIDTH(6), .MSB_FIRST(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst_i), .word_i(word6), .word_valid_i(wv[0]),
        .word_ready_o(rdy[0]), .hold_i(hold_i), .data_o(dat[0]),
        .valid_o(vo[0]), .last_o(lo[0]), .busy_o(bo[0])
    );

    pd_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst_i), .word_i(word8), .word_valid_i(wv[1]),
        .word_ready_o(rdy[1]), .hold_i(hold_i), .data_o(dat[1]),
        .valid_o(vo[1]), .last_o(lo[1]), .busy_o(bo[1])
    );

    int errors = 0;
    int checks = 0;

    // Model state: bits still to be presented, one buffered word, word-in-flight flag.
    bit          e_data[2], e_valid[2], e_last[2], e_busy[2], e_ready[2];
    bit          inword[2], buff[2];
    logic [31:0] bufw[2];
    bit          bitq[2][$];
    logic [31:0] pend[2][$];
    bit          rand_mode = 1'b0;

    // Capture of the observed serial stream per instance.
    int          cyc = 0;
    int          nbits[2], first_c[2], last_c[2];
    logic [63:0] pk[2], lmask[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cap_clear();
        for (int i = 0; i < 2; i++) begin
            nbits[i]   = 0;
            pk[i]      = '0;
            lmask[i]   = '0;
            first_c[i] = -1;
            last_c[i]  = -1;
        end
    endtask

    // One clock edge of the behavioural model for instance i.
    task automatic model_step(input int i, input int w, input bit msb, input bit rst,
                              input bit vin, input logic [31:0] win, input bit hold,
                              output bit acc);
        logic [31:0] nw;
        bit          have_next;
        acc = 1'b0;
        if (rst) begin
            bitq[i].delete();
            buff[i]    = 1'b0;
            inword[i]  = 1'b0;
            e_data[i]  = 1'b0;
            e_valid[i] = 1'b0;
            e_last[i]  = 1'b0;
            e_busy[i]  = 1'b0;
            e_ready[i] = 1'b1;
            return;
        end
        acc        = vin && e_ready[i];
        e_valid[i] = 1'b0;
        e_last[i]  = 1'b0;
        if (hold) begin
            if (acc) begin bufw[i] = win; buff[i] = 1'b1; end
        end else if (bitq[i].size() > 0) begin
            e_data[i]  = bitq[i].pop_front();
            e_valid[i] = 1'b1;
            e_last[i]  = (bitq[i].size() == 0);
            if (acc) begin bufw[i] = win; buff[i] = 1'b1; end
        end else begin
            have_next = 1'b0;
            nw        = '0;
            if (buff[i]) begin
                nw = bufw[i]; buff[i] = 1'b0; have_next = 1'b1;
            end else if (acc) begin
                nw = win; have_next = 1'b1;
            end
            if (have_next) begin
                for (int n = 0; n < w; n++)
                    bitq[i].push_back(msb ? nw[w-1-n] : nw[n]);
                e_data[i]  = bitq[i].pop_front();
                e_valid[i] = 1'b1;
                inword[i]  = 1'b1;
            end else begin
                inword[i] = 1'b0;
            end
        end
        e_ready[i] = !buff[i];
        e_busy[i]  = inword[i] || buff[i];
    endtask

    task automatic compare(input int i);
        chk($sformatf("u%0d valid_o cyc%0d", i, cyc), 64'(vo[i]), 64'(e_valid[i]));
        chk($sformatf("u%0d last_o cyc%0d", i, cyc), 64'(lo[i]), 64'(e_last[i]));
        chk($sformatf("u%0d busy_o cyc%0d", i, cyc), 64'(bo[i]), 64'(e_busy[i]));
        chk($sformatf("u%0d word_ready_o cyc%0d", i, cyc), 64'(rdy[i]), 64'(e_ready[i]));
        if (e_valid[i])
            chk($sformatf("u%0d data_o cyc%0d", i, cyc), 64'(dat[i]), 64'(e_data[i]));
        if (vo[i] === 1'b1) begin
            if (first_c[i] < 0) first_c[i] = cyc;
            last_c[i] = cyc;
            pk[i]     = {pk[i][62:0], dat[i]};
            if (lo[i] === 1'b1) lmask[i][nbits[i]] = 1'b1;
            nbits[i]++;
        end
    endtask

    // Drive one cycle, advance the model at the edge, compare at the falling edge.
    task automatic step(input bit rst, input bit hold);
        bit          v0, v1, a0, a1;
        logic [31:0] w0, w1;
        v0 = (pend[0].size() > 0) && (!rand_mode || $urandom_range(3) != 0);
        v1 = (pend[1].size() > 0) && (!rand_mode || $urandom_range(3) != 0);
        w0 = v0 ? pend[0][0] : $urandom;
        w1 = v1 ? pend[1][0] : $urandom;
        rst_i  = rst;
        hold_i = hold;
        wv[0]  = v0;
        wv[1]  = v1;
        word6  = w0[5:0];
        word8  = w1[7:0];
        @(posedge clk);
        model_step(0, 6, 1'b1, rst, v0, {26'b0, w0[5:0]}, hold, a0);
        model_step(1, 8, 1'b0, rst, v1, {24'b0, w1[7:0]}, hold, a1);
        if (a0) void'(pend[0].pop_front());
        if (a1) void'(pend[1].pop_front());
        @(negedge clk);
        cyc++;
        compare(0);
        compare(1);
    endtask

    initial begin
        rst_i  = 1'b1;
        hold_i = 1'b0;
        wv     = '0;
        word6  = '0;
        word8  = '0;
        cap_clear();

        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset data_o u%0d", i), 64'(dat[i]), 64'(0));
            chk($sformatf("reset valid_o u%0d", i), 64'(vo[i]), 64'(0));
            chk($sformatf("reset busy_o u%0d", i), 64'(bo[i]), 64'(0));
            chk($sformatf("reset ready u%0d", i), 64'(rdy[i]), 64'(1));
        end

        // Single word 110110, MSB first
        cap_clear();
        pend[0].push_back(32'h36);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0);
        chk("single last in cycle 6", 64'(lo[0]), 64'(1));
        chk("single busy in cycle 6", 64'(bo[0]), 64'(1));
        step(1'b0, 1'b0);
        chk("single busy after word", 64'(bo[0]), 64'(0));
        chk("single bits", pk[0], 64'(6'b110110));
        chk("single nbits", 64'(nbits[0]), 64'(6));
        chk("single last mask", lmask[0], 64'h20);

        // Three back-to-back words with valid held high
        cap_clear();
        pend[0].push_back(32'h36);
        pend[0].push_back(32'h36);
        pend[0].push_back(32'h00);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("stream ready low with buffer full", 64'(rdy[0]), 64'(0));
        for (int k = 0; k < 18; k++) step(1'b0, 1'b0);
        chk("stream nbits", 64'(nbits[0]), 64'(18));
        chk("stream gap", 64'((last_c[0] - first_c[0] + 1) - nbits[0]), 64'(0));
        chk("stream bits", pk[0], 64'(18'b110110_110110_000000));
        chk("stream last mask", lmask[0], 64'h20820);

        // Hold for 3 cycles after bit 2 of A5, LSB first
        cap_clear();
        pend[1].push_back(32'hA5);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0);
        chk("hold nbits", 64'(nbits[1]), 64'(8));
        chk("hold gap", 64'((last_c[1] - first_c[1] + 1) - nbits[1]), 64'(3));
        chk("hold bits", pk[1], 64'(8'b10100101));
        chk("hold last mask", lmask[1], 64'h80);

        // LSB first word 01
        cap_clear();
        pend[1].push_back(32'h01);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0);
        chk("lsb bits", pk[1], 64'(8'b10000000));
        chk("lsb nbits", 64'(nbits[1]), 64'(8));

        // Reset at bit 4 with the buffer full
        pend[0].push_back(32'h2A);
        pend[0].push_back(32'h15);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        chk("pre-reset ready", 64'(rdy[0]), 64'(0));
        step(1'b1, 1'b0);
        chk("mid reset valid_o", 64'(vo[0]), 64'(0));
        chk("mid reset busy_o", 64'(bo[0]), 64'(0));
        chk("mid reset ready", 64'(rdy[0]), 64'(1));
        pend[0].delete();
        cap_clear();
        pend[0].push_back(32'h3C);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        chk("post reset bits", pk[0], 64'(6'b111100));
        chk("post reset nbits", 64'(nbits[0]), 64'(6));

        // Word arriving one cycle after the previous last bit
        cap_clear();
        pend[0].push_back(32'h2D);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0);
        pend[0].push_back(32'h12);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        chk("late word nbits", 64'(nbits[0]), 64'(12));
        chk("late word gap", 64'((last_c[0] - first_c[0] + 1) - nbits[0]), 64'(1));
        chk("late word bits", pk[0], 64'(12'b101101_010010));

        // Randomized traffic, hold and occasional reset
        rand_mode = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 2; i++)
                if (pend[i].size() < 2 && $urandom_range(2) == 0)
                    pend[i].push_back($urandom);
            step($urandom_range(299) == 0, $urandom_range(7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
